bnn_conv3x3_multi: RTL

BNN_CONV3X3_MULTI -- requirements
Module: bnn_conv3x3_multi

---
 rtl/bnn_conv3x3_multi.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/bnn_conv3x3_multi.sv
// Binary 3x3 convolution engine.
// Loads NUM_K binary kernels with thresholds from the weight SRAM. It then walks
// a header-delimited list of NxN bit images in the input SRAM. For each image and
// kernel it writes N-2 thresholded XNOR-popcount rows to the output SRAM.
module bnn_conv3x3_multi #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 12,
    parameter int                NUM_K     = 2,
    parameter logic [DATA_W-1:0] TERM_WORD = DATA_W'(16'h00FF)
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic              dut_error,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data
);

    typedef enum logic [2:0] {IDLE, LOADW, HEADER, CONV, DONE} state_t;

    localparam logic [1:0] LAST_K = 2'(NUM_K - 1);

    state_t            state;
    // Read pipeline: _p0 = address on the bus, _p1 = data on the bus this cycle.
    logic              vld_p0, vld_p1;
    logic              hdr_p0, hdr_p1;
    logic [5:0]        iss_cnt, rcv_cnt, n_q;
    logic [1:0]        k_idx;
    logic [ADDR_W-1:0] hdr_addr;
    logic [DATA_W-1:0] hdr_q, win_r0, win_r1;
    logic              hdr_req, hdr_vld;
    logic [8:0]        wt [4];
    logic [3:0]        th [4];
    logic [5:0]        hdr_n;
    logic              hdr_bad;
    logic              unused_wbits;

    assign hdr_n   = hdr_q[5:0];
    assign hdr_bad = (hdr_n < 6'd3) || ({26'd0, hdr_n} > 32'(DATA_W));
    // Weight-word bits above the threshold field have no meaning.
    assign unused_wbits = ^wmem_dut_read_data[DATA_W-1:13];

    function automatic logic [3:0] popcnt9(input logic [8:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 9; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    // Out-of-range thresholds fall back to a majority-style default of 5.
    function automatic logic [3:0] fix_thr(input logic [3:0] t);
        return (t == 4'd0 || t > 4'd9) ? 4'd5 : t;
    endfunction

    // One output row from rows r-2 (r0), r-1 (r1) and r (r2); bits >= N-2 stay 0.
    function automatic logic [DATA_W-1:0] conv_row(input logic [DATA_W-1:0] r0,
                                                   input logic [DATA_W-1:0] r1,
                                                   input logic [DATA_W-1:0] r2,
                                                   input logic [8:0]        w,
                                                   input logic [3:0]        t,
                                                   input logic [5:0]        n);
        logic [DATA_W-1:0] res;
        logic [8:0]        win;
        res = '0;
        for (int j = 0; j < DATA_W - 2; j++) begin
            win = {r2[j+2], r2[j+1], r2[j], r1[j+2], r1[j+1], r1[j], r0[j+2], r0[j+1], r0[j]};
            if ((j + 2 < {26'd0, n}) && (popcnt9(~(w ^ win)) >= t)) res[j] = 1'b1;
        end
        return res;
    endfunction

    // Job controller: weight load, header walk, per-kernel row passes and output writes.
    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            state                  <= IDLE;
            vld_p0                 <= 1'b0;
            vld_p1                 <= 1'b0;
            hdr_p0                 <= 1'b0;
            hdr_p1                 <= 1'b0;
            iss_cnt                <= '0;
            rcv_cnt                <= '0;
            n_q                    <= '0;
            k_idx                  <= '0;
            hdr_addr               <= '0;
            hdr_q                  <= '0;
            win_r0                 <= '0;
            win_r1                 <= '0;
            hdr_req                <= 1'b0;
            hdr_vld                <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                wt[i] <= '0;
                th[i] <= '0;
            end
            dut_busy               <= 1'b0;
            dut_error              <= 1'b0;
            dut_sram_read_address  <= '0;
            dut_sram_write_address <= '0;
            dut_sram_write_data    <= '0;
            dut_sram_write_enable  <= 1'b0;
            dut_wmem_read_address  <= '0;
        end else begin
            vld_p0                <= 1'b0;
            hdr_p0                <= 1'b0;
            vld_p1                <= vld_p0;
            hdr_p1                <= hdr_p0;
            dut_sram_write_enable <= 1'b0;
            if (dut_sram_write_enable) dut_sram_write_address <= dut_sram_write_address + ADDR_W'(1);
            if (vld_p1 && hdr_p1) begin
                hdr_q   <= sram_dut_read_data;
                hdr_vld <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (dut_run) begin
                        state                  <= LOADW;
                        dut_busy               <= 1'b1;
                        dut_error              <= 1'b0;
                        hdr_addr               <= '0;
                        dut_sram_read_address  <= '0;
                        dut_sram_write_address <= '0;
                        iss_cnt                <= '0;
                        rcv_cnt                <= '0;
                        hdr_req                <= 1'b0;
                        hdr_vld                <= 1'b0;
                    end
                end
                LOADW: begin
                    if (iss_cnt < 6'(NUM_K)) begin
                        dut_wmem_read_address <= ADDR_W'(iss_cnt) + ADDR_W'(1);
                        vld_p0                <= 1'b1;
                        iss_cnt               <= iss_cnt + 6'd1;
                    end
                    if (vld_p1) begin
                        wt[rcv_cnt[1:0]] <= wmem_dut_read_data[8:0];
                        th[rcv_cnt[1:0]] <= fix_thr(wmem_dut_read_data[12:9]);
                        rcv_cnt          <= rcv_cnt + 6'd1;
                        if (rcv_cnt == 6'(NUM_K - 1)) begin
                            state   <= HEADER;
                            iss_cnt <= '0;
                            rcv_cnt <= '0;
                        end
                    end
                end
                HEADER: begin
                    // The header may already have been prefetched by the last pass.
                    if (hdr_vld) begin
                        hdr_vld <= 1'b0;
                        hdr_req <= 1'b0;
                        if (hdr_q == TERM_WORD) begin
                            state <= DONE;
                        end else if (hdr_bad) begin
                            dut_error <= 1'b1;
                            state     <= DONE;
                        end else begin
                            n_q     <= hdr_n;
                            k_idx   <= '0;
                            iss_cnt <= '0;
                            rcv_cnt <= '0;
                            state   <= CONV;
                        end
                    end else if (!hdr_req) begin
                        dut_sram_read_address <= hdr_addr;
                        vld_p0                <= 1'b1;
                        hdr_p0                <= 1'b1;
                        hdr_req               <= 1'b1;
                    end
                end
                CONV: begin
                    if (iss_cnt < n_q) begin
                        dut_sram_read_address <= hdr_addr + ADDR_W'(iss_cnt) + ADDR_W'(1);
                        vld_p0                <= 1'b1;
                        iss_cnt               <= iss_cnt + 6'd1;
                    end else if (k_idx == LAST_K && !hdr_req) begin
                        // Fetch the next header behind the last row to shorten the tail.
                        dut_sram_read_address <= hdr_addr + ADDR_W'(n_q) + ADDR_W'(1);
                        vld_p0                <= 1'b1;
                        hdr_p0                <= 1'b1;
                        hdr_req               <= 1'b1;
                    end
                    if (vld_p1 && !hdr_p1) begin
                        win_r0  <= win_r1;
                        win_r1  <= sram_dut_read_data;
                        rcv_cnt <= rcv_cnt + 6'd1;
                        if (rcv_cnt >= 6'd2) begin
                            dut_sram_write_enable <= 1'b1;
                            dut_sram_write_data   <= conv_row(win_r0, win_r1, sram_dut_read_data,
                                                              wt[k_idx], th[k_idx], n_q);
                        end
                    end
                    if (rcv_cnt == n_q) begin
                        iss_cnt <= '0;
                        rcv_cnt <= '0;
                        if (k_idx == LAST_K) begin
                            hdr_addr <= hdr_addr + ADDR_W'(n_q) + ADDR_W'(1);
                            state    <= HEADER;
                        end else begin
                            k_idx <= k_idx + 2'd1;
                        end
                    end
                end
                DONE: begin
                    dut_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
